dual_port_lutram_sweep: RTL and testbench
=========================================

Name: dual_port_lutram_sweep

Overview:
- Simple dual-port LUTRAM: one write port with byte enables, one registered read port.
- Configurable read latency and read-during-write bypass.
- Built-in sweep engine zeroes the array after reset and on an explicit flush request. No reset fan-out into the storage, so it stays LUTRAM-inferable.
- Used for cache tag/data arrays, branch predictor tables and TLB storage in the core and memory subsystem.

Parameters:
- SINGLE_ELEMENT_SIZE_IN_BITS, 64, element width. Must be a multiple of 8.
- NUMBER_SETS, 64, array depth. Must be ≥2.
- SET_PTR_WIDTH_IN_BITS, $clog2(NUMBER_SETS), address width.
- BYTE_EN_WIDTH, SINGLE_ELEMENT_SIZE_IN_BITS/8, number of write byte lanes.
- READ_LATENCY, 1, read_en_in to data-out latency in cycles. Legal values: 1 or 2.
- WRITE_FIRST_BYPASS, 1, on a same-cycle same-address collision: 1 = read returns the merged new data, 0 = read returns the old data.

Ports:
- clk_in  input  1  clock; all state on the rising edge.
- reset_n_in  input  1  asynchronous active-low reset.
- flush_in  input  1  request to zero the whole array.
- busy_out  output  1  sweep in progress; writes are ignored while high.
- write_en_in  input  1  write request.
- write_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  write set index.
- write_byte_en_in  input  BYTE_EN_WIDTH  per-byte write mask; bit i covers bits [8i+7:8i].
- write_element_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  write data.
- read_en_in  input  1  read request.
- read_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  read set index.
- read_element_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  read data; holds its value between reads.
- read_valid_out  output  1  one-cycle pulse aligned with new read_element_out.

Behaviour:
- Reset (reset_n_in low, asynchronous):
  - State = SWEEP, sweep pointer = 0, busy_out = 1.
  - read_element_out = 0, read_valid_out = 0, all read pipeline valids = 0.
  - Storage array is not reset.
- FSM states:
  - IDLE: busy_out = 0.
  - SWEEP: busy_out = 1. Each cycle writes all-zero to set[ptr] (full byte mask), then ptr += 1.
    - When ptr == NUMBER_SETS-1 the write completes and the next state is IDLE. ptr returns to 0.
    - The sweep takes exactly NUMBER_SETS cycles. busy_out falls on the edge that writes the last set.
  - IDLE -> SWEEP: flush_in high in IDLE. busy_out rises on the next edge.
  - SWEEP -> SWEEP: flush_in during a sweep is ignored. The sweep neither restarts nor extends.
- Writes:
  - Accepted only when busy_out == 0 and write_en_in == 1.
  - Only the bytes with write_byte_en_in[i] = 1 are updated. write_byte_en_in == 0 is a no-op.
  - Writes issued while busy_out == 1 are silently dropped. No error and no queueing.
- Reads:
  - Allowed in every state, including SWEEP.
  - READ_LATENCY=1: read_element_out and read_valid_out update on the edge after read_en_in.
  - READ_LATENCY=2: one extra register stage; data and valid appear two edges after read_en_in.
  - Back-to-back reads are supported at one per cycle for either latency.
  - read_element_out changes only when valid data arrives; otherwise it holds.
- Collision (read and write of the same set in the same cycle):
  - The effective writer is either an accepted user write or the sweep write.
  - WRITE_FIRST_BYPASS=1: the read returns old data with the written bytes replaced. A sweep collision returns all-zero.
  - WRITE_FIRST_BYPASS=0: the read returns the pre-write contents.
  - Bypass is resolved at issue and travels down the read pipeline. A write in a later cycle does not affect an in-flight read.
- Reset asserted mid-sweep or mid-read: in-flight reads are discarded, and the sweep restarts from set 0 after release.
- Addresses ≥ NUMBER_SETS (non-power-of-2 depth): reads return 0 and writes are dropped; read_valid_out still pulses.

Test Plan:
- Reset then release with NUMBER_SETS=64 -> busy_out high for exactly 64 cycles after release; afterwards a read of every set returns 0.
- Write 0xFFFF_FFFF_FFFF_FFFF to set 5, then write byte_en=8'h0F, data 0x1122_3344_5566_7788 to set 5, then read set 5 -> 0xFFFF_FFFF_5566_7788 after READ_LATENCY cycles, with read_valid_out pulsing once.
- Same-cycle write of 0xAB..AB (full mask) and read of set 9, which previously held 0x0 -> BYPASS=1 returns 0xAB..AB; BYPASS=0 returns 0x0. A following read returns 0xAB..AB in both cases.
- flush_in in IDLE, with a write to set 3 two cycles later and a second flush_in mid-sweep -> the write is dropped, the sweep lasts exactly NUMBER_SETS cycles, and set 3 reads 0.
- reset_n_in pulsed low at sweep ptr=20 while a READ_LATENCY=2 read is in flight -> no read_valid_out pulse; after release the sweep restarts at 0 and completes in 64 cycles.
- Back-to-back reads of sets 63, 0, 1 with READ_LATENCY=2 -> three consecutive valid pulses with the correct data, starting two cycles after the first request.

Source files
------------

// File: rtl/dual_port_lutram_sweep.sv
// Simple dual-port LUTRAM with byte-enable write port, registered read port
// (1 or 2 cycles), optional write-first bypass and a zeroing sweep engine that
// runs after reset and on flush. The storage array itself is never reset.
module dual_port_lutram_sweep #(
  parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int unsigned NUMBER_SETS                 = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
  parameter int unsigned BYTE_EN_WIDTH               = SINGLE_ELEMENT_SIZE_IN_BITS / 8,
  parameter int unsigned READ_LATENCY                = 1,
  parameter bit          WRITE_FIRST_BYPASS          = 1'b1
) (
  input  logic                                   clk_in,
  input  logic                                   reset_n_in,
  input  logic                                   flush_in,
  output logic                                   busy_out,
  input  logic                                   write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       write_set_addr_in,
  input  logic [BYTE_EN_WIDTH-1:0]               write_byte_en_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_element_in,
  input  logic                                   read_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       read_set_addr_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_element_out,
  output logic                                   read_valid_out
);

  localparam int unsigned W  = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int unsigned AW = SET_PTR_WIDTH_IN_BITS;
  localparam int unsigned NumSetsInt = NUMBER_SETS;
  localparam logic [AW:0]   NumSetsExt = NumSetsInt[AW:0];
  localparam logic [AW-1:0] LastSet    = AW'(NUMBER_SETS - 1);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [W-1:0]        mem [NUMBER_SETS];

  logic                wr_en_c;
  logic [AW-1:0]       wr_addr_c;
  logic [BYTE_EN_WIDTH-1:0] wr_mask_c;
  logic [W-1:0]        wr_data_c;
  logic                wr_in_range, rd_in_range;
  logic [W-1:0]        rd_old_c, rd_data_c;
  logic                out_valid_c;
  logic [W-1:0]        out_data_c;
  logic                valid_q;
  logic [W-1:0]        elem_q;

  assign busy_out         = (state_q == StSweep);
  assign read_valid_out   = valid_q;
  assign read_element_out = elem_q;

  // Out-of-range addresses only exist for non-power-of-2 depths.
  assign wr_in_range = ({1'b0, write_set_addr_in} < NumSetsExt);
  assign rd_in_range = ({1'b0, read_set_addr_in} < NumSetsExt);

  // Sweep FSM next-state: walk every set once, then return to idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (flush_in) state_d = StSweep;
      end
      StSweep: begin
        if (ptr_q == LastSet) begin
          state_d = StIdle;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register; reset restarts the sweep from set 0.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= StSweep;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Effective writer: the sweep owns the port while busy, user writes are dropped.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = '0;
    wr_mask_c = '0;
    wr_data_c = '0;
    if (state_q == StSweep) begin
      wr_en_c   = 1'b1;
      wr_addr_c = ptr_q;
      wr_mask_c = '1;
    end else if (write_en_in && wr_in_range) begin
      wr_en_c   = 1'b1;
      wr_addr_c = write_set_addr_in;
      wr_mask_c = write_byte_en_in;
      wr_data_c = write_element_in;
    end
  end

  // Storage write, byte-lane masked; no reset so it maps onto LUTRAM.
  always_ff @(posedge clk_in) begin
    if (wr_en_c) begin
      for (int b = 0; b < int'(BYTE_EN_WIDTH); b++) begin
        if (wr_mask_c[b]) mem[wr_addr_c][8*b +: 8] <= wr_data_c[8*b +: 8];
      end
    end
  end

  // Read data at issue, with same-cycle collision merge when write-first.
  always_comb begin
    rd_old_c  = rd_in_range ? mem[read_set_addr_in] : '0;
    rd_data_c = rd_old_c;
    if (WRITE_FIRST_BYPASS && wr_en_c && rd_in_range && (wr_addr_c == read_set_addr_in)) begin
      for (int b = 0; b < int'(BYTE_EN_WIDTH); b++) begin
        if (wr_mask_c[b]) rd_data_c[8*b +: 8] = wr_data_c[8*b +: 8];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic         s1_valid_q;
    logic [W-1:0] s1_data_q;

    // Extra read stage; data captured at issue so later writes cannot disturb it.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= read_en_in;
        if (read_en_in) s1_data_q <= rd_data_c;
      end
    end

    assign out_valid_c = s1_valid_q;
    assign out_data_c  = s1_data_q;
  end else begin : g_lat1
    assign out_valid_c = read_en_in;
    assign out_data_c  = rd_data_c;
  end

  // Output stage: valid pulses per read, data holds between reads.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      valid_q <= 1'b0;
      elem_q  <= '0;
    end else begin
      valid_q <= out_valid_c;
      if (out_valid_c) elem_q <= out_data_c;
    end
  end

endmodule

// File: tb/tb_dual_port_lutram_sweep.sv
// Directed bench: instance A is latency 1 / write-first, instance B is
// latency 2 / read-first; both share the same stimulus.
module tb_dual_port_lutram_sweep;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        flush_in;
  logic        write_en_in;
  logic [5:0]  write_set_addr_in;
  logic [7:0]  write_byte_en_in;
  logic [63:0] write_element_in;
  logic        read_en_in;
  logic [5:0]  read_set_addr_in;
  logic        a_busy, b_busy, a_valid, b_valid;
  logic [63:0] a_elem, b_elem;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  dual_port_lutram_sweep #(.READ_LATENCY(1), .WRITE_FIRST_BYPASS(1'b1)) dut_a (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .flush_in(flush_in), .busy_out(a_busy),
    .write_en_in(write_en_in), .write_set_addr_in(write_set_addr_in),
    .write_byte_en_in(write_byte_en_in), .write_element_in(write_element_in),
    .read_en_in(read_en_in), .read_set_addr_in(read_set_addr_in),
    .read_element_out(a_elem), .read_valid_out(a_valid)
  );

  dual_port_lutram_sweep #(.READ_LATENCY(2), .WRITE_FIRST_BYPASS(1'b0)) dut_b (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .flush_in(flush_in), .busy_out(b_busy),
    .write_en_in(write_en_in), .write_set_addr_in(write_set_addr_in),
    .write_byte_en_in(write_byte_en_in), .write_element_in(write_element_in),
    .read_en_in(read_en_in), .read_set_addr_in(read_set_addr_in),
    .read_element_out(b_elem), .read_valid_out(b_valid)
  );

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic drive_write(input logic en, input logic [5:0] addr, input logic [7:0] be,
                             input logic [63:0] data);
    write_en_in       = en;
    write_set_addr_in = addr;
    write_byte_en_in  = be;
    write_element_in  = data;
  endtask

  task automatic drive_read(input logic en, input logic [5:0] addr);
    read_en_in       = en;
    read_set_addr_in = addr;
  endtask

  task automatic test_reset();
    int cnt;
    tick(); tick();
    total++;
    if ({a_busy, b_busy, a_valid, b_valid} !== 4'b1100) begin
      bad++; $display("FAIL reset_flags got=%b exp=1100", {a_busy, b_busy, a_valid, b_valid});
    end
    total++;
    if ({a_elem, b_elem} !== 128'd0) begin
      bad++; $display("FAIL reset_elem got=%h/%h exp=0", a_elem, b_elem);
    end
    reset_n_in = 1'b1;
    cnt = 0;
    while (a_busy && cnt < 200) begin cnt++; tick(); end
    total++;
    if (cnt !== 64) begin bad++; $display("FAIL reset_sweep_len got=%0d exp=64", cnt); end
    for (int s = 0; s < 64; s++) begin
      drive_read(1'b1, 6'(s));
      tick();
      total++;
      if ({a_valid, a_elem} !== {1'b1, 64'd0}) begin
        bad++; $display("FAIL sweep_zero_a set=%0d got=%b/%h exp=1/0", s, a_valid, a_elem);
      end
      drive_read(1'b0, 6'd0);
      tick();
      total++;
      if ({b_valid, b_elem} !== {1'b1, 64'd0}) begin
        bad++; $display("FAIL sweep_zero_b set=%0d got=%b/%h exp=1/0", s, b_valid, b_elem);
      end
    end
  endtask

  task automatic test_byte_enable();
    drive_write(1'b1, 6'd5, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF); tick();
    drive_write(1'b1, 6'd5, 8'h0F, 64'h1122_3344_5566_7788); tick();
    drive_write(1'b0, 6'd0, 8'h00, 64'd0);
    drive_read(1'b1, 6'd5); tick();
    total++;
    if ({a_valid, a_elem} !== {1'b1, 64'hFFFF_FFFF_5566_7788}) begin
      bad++; $display("FAIL be_a got=%b/%h exp=1/ffffffff55667788", a_valid, a_elem);
    end
    total++;
    if (b_valid !== 1'b0) begin bad++; $display("FAIL be_b_early got=%b exp=0", b_valid); end
    drive_read(1'b0, 6'd0); tick();
    total++;
    if ({a_valid, a_elem} !== {1'b0, 64'hFFFF_FFFF_5566_7788}) begin
      bad++; $display("FAIL be_a_hold got=%b/%h exp=0/ffffffff55667788", a_valid, a_elem);
    end
    total++;
    if ({b_valid, b_elem} !== {1'b1, 64'hFFFF_FFFF_5566_7788}) begin
      bad++; $display("FAIL be_b got=%b/%h exp=1/ffffffff55667788", b_valid, b_elem);
    end
    tick();
    total++;
    if ({b_valid, b_elem} !== {1'b0, 64'hFFFF_FFFF_5566_7788}) begin
      bad++; $display("FAIL be_b_hold got=%b/%h exp=0/ffffffff55667788", b_valid, b_elem);
    end
  endtask

  task automatic test_collision();
    drive_write(1'b1, 6'd9, 8'hFF, 64'hABAB_ABAB_ABAB_ABAB);
    drive_read(1'b1, 6'd9); tick();
    total++;
    if ({a_valid, a_elem} !== {1'b1, 64'hABAB_ABAB_ABAB_ABAB}) begin
      bad++; $display("FAIL coll_a_bypass got=%b/%h exp=1/abababababababab", a_valid, a_elem);
    end
    drive_write(1'b0, 6'd0, 8'h00, 64'd0); tick();
    total++;
    if ({b_valid, b_elem} !== {1'b1, 64'd0}) begin
      bad++; $display("FAIL coll_b_old got=%b/%h exp=1/0", b_valid, b_elem);
    end
    total++;
    if ({a_valid, a_elem} !== {1'b1, 64'hABAB_ABAB_ABAB_ABAB}) begin
      bad++; $display("FAIL coll_a_after got=%b/%h exp=1/abababababababab", a_valid, a_elem);
    end
    // Partial-lane collision while B's previous read is still in flight.
    drive_write(1'b1, 6'd9, 8'h01, 64'h0000_0000_0000_00CD); tick();
    total++;
    if ({b_valid, b_elem} !== {1'b1, 64'hABAB_ABAB_ABAB_ABAB}) begin
      bad++; $display("FAIL coll_b_after got=%b/%h exp=1/abababababababab", b_valid, b_elem);
    end
    total++;
    if ({a_valid, a_elem} !== {1'b1, 64'hABAB_ABAB_ABAB_ABCD}) begin
      bad++; $display("FAIL coll_a_partial got=%b/%h exp=1/abababababababcd", a_valid, a_elem);
    end
    drive_write(1'b0, 6'd0, 8'h00, 64'd0); tick();
    total++;
    if ({b_valid, b_elem} !== {1'b1, 64'hABAB_ABAB_ABAB_ABAB}) begin
      bad++; $display("FAIL coll_b_partial got=%b/%h exp=1/abababababababab", b_valid, b_elem);
    end
    total++;
    if ({a_valid, a_elem} !== {1'b1, 64'hABAB_ABAB_ABAB_ABCD}) begin
      bad++; $display("FAIL coll_a_reread got=%b/%h exp=1/abababababababcd", a_valid, a_elem);
    end
    drive_read(1'b0, 6'd0); tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] v63, v0, v1;
    v63 = 64'hDEAD_BEEF_0000_0063;
    v0  = 64'h0123_4567_89AB_CDEF;
    v1  = 64'hFEDC_BA98_7654_3210;
    drive_write(1'b1, 6'd63, 8'hFF, v63); tick();
    drive_write(1'b1, 6'd0, 8'hFF, v0); tick();
    drive_write(1'b1, 6'd1, 8'hFF, v1); tick();
    drive_write(1'b0, 6'd0, 8'h00, 64'd0);
    drive_read(1'b1, 6'd63); tick();
    total++;
    if ({a_valid, a_elem, b_valid} !== {1'b1, v63, 1'b0}) begin
      bad++; $display("FAIL b2b_0 got=%b/%h/%b exp=1/%h/0", a_valid, a_elem, b_valid, v63);
    end
    drive_read(1'b1, 6'd0); tick();
    total++;
    if ({a_valid, a_elem, b_valid, b_elem} !== {1'b1, v0, 1'b1, v63}) begin
      bad++; $display("FAIL b2b_1 got=%h/%h exp=%h/%h", a_elem, b_elem, v0, v63);
    end
    drive_read(1'b1, 6'd1); tick();
    total++;
    if ({a_valid, a_elem, b_valid, b_elem} !== {1'b1, v1, 1'b1, v0}) begin
      bad++; $display("FAIL b2b_2 got=%h/%h exp=%h/%h", a_elem, b_elem, v1, v0);
    end
    drive_read(1'b0, 6'd0); tick();
    total++;
    if ({a_valid, a_elem, b_valid, b_elem} !== {1'b0, v1, 1'b1, v1}) begin
      bad++; $display("FAIL b2b_3 got=%b/%h/%b/%h exp=0/%h/1/%h", a_valid, a_elem, b_valid,
                      b_elem, v1, v1);
    end
    tick();
    total++;
    if ({b_valid, b_elem} !== {1'b0, v1}) begin
      bad++; $display("FAIL b2b_4 got=%b/%h exp=0/%h", b_valid, b_elem, v1);
    end
  endtask

  task automatic test_flush();
    int cnt;
    logic [5:0] sets [4];
    sets = '{6'd3, 6'd2, 6'd5, 6'd63};
    flush_in = 1'b1; tick();
    flush_in = 1'b0;
    cnt = 0;
    while (a_busy && cnt < 200) begin
      drive_write(1'b0, 6'd0, 8'h00, 64'd0);
      flush_in = 1'b0;
      if (cnt == 1) drive_write(1'b1, 6'd3, 8'hFF, 64'h5555_5555_5555_5555);
      if (cnt == 10) flush_in = 1'b1;
      if (cnt == 40) drive_write(1'b1, 6'd2, 8'hFF, 64'h7777_7777_7777_7777);
      cnt++;
      tick();
    end
    drive_write(1'b0, 6'd0, 8'h00, 64'd0);
    flush_in = 1'b0;
    total++;
    if (cnt !== 64) begin bad++; $display("FAIL flush_len got=%0d exp=64", cnt); end
    foreach (sets[i]) begin
      drive_read(1'b1, sets[i]); tick();
      total++;
      if ({a_valid, a_elem} !== {1'b1, 64'd0}) begin
        bad++; $display("FAIL flush_zero set=%0d got=%b/%h exp=1/0", sets[i], a_valid, a_elem);
      end
    end
    drive_read(1'b0, 6'd0); tick(); tick();
  endtask

  task automatic test_reset_mid();
    int cnt;
    int pulses;
    flush_in = 1'b1; tick();
    flush_in = 1'b0;
    repeat (19) tick();
    drive_read(1'b1, 6'd0); tick();
    drive_read(1'b0, 6'd0);
    #1 reset_n_in = 1'b0;
    #1;
    total++;
    if ({a_valid, b_valid, a_busy, a_elem} !== {3'b001, 64'd0}) begin
      bad++; $display("FAIL rst_mid got=%b%b%b/%h exp=001/0", a_valid, b_valid, a_busy, a_elem);
    end
    tick();
    reset_n_in = 1'b1;
    cnt = 0;
    pulses = 0;
    while (a_busy && cnt < 200) begin
      if (a_valid || b_valid) pulses++;
      cnt++;
      tick();
    end
    if (a_valid || b_valid) pulses++;
    total++;
    if (cnt !== 64) begin bad++; $display("FAIL rst_mid_len got=%0d exp=64", cnt); end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL rst_mid_pulse got=%0d exp=0", pulses); end
  endtask

  initial begin
    reset_n_in = 1'b0;
    flush_in   = 1'b0;
    drive_write(1'b0, 6'd0, 8'h00, 64'd0);
    drive_read(1'b0, 6'd0);
    test_reset();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
